// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// iteration-counter sizing and the divide-by-zero quotient fill.
package div_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_e;

  // Counter must be able to represent WIDTH steps.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Each quotient bit is filled with this value on divide-by-zero (all ones).
  localparam logic DBZ_FILL = 1'b1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference only when it does not borrow.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0]   p;
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic             unused_rem_msb;

  // The partial remainder is always below the divisor, so its top bit is
  // never significant when shifting.
  assign unused_rem_msb = rem_i[WIDTH];

  assign p      = {rem_i[WIDTH-1:0], q_i[WIDTH-1]};
  assign diff   = {1'b0, p} - {2'b00, divisor_i};
  assign borrow = diff[WIDTH+1];
  assign rem_o  = borrow ? p : diff[WIDTH:0];
  assign q_o    = {q_i[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with a start/busy/valid handshake.
// start is accepted whenever busy=0; valid pulses for one cycle per result.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             pend_q, pend_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remd_q, remd_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .q_i       (q_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    pend_d  = 1'b0;
    valid_d = 1'b0;
    quot_d  = quot_q;
    remd_d  = remd_q;
    dbz_d   = dbz_q;

    // A divide-by-zero accepted last edge publishes now; q_q still holds
    // that dividend even if a new operation is being captured this edge.
    if (pend_q) begin
      valid_d = 1'b1;
      quot_d  = {WIDTH{DBZ_FILL}};
      remd_d  = q_q;
      dbz_d   = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          q_d   = dividend;
          dvs_d = divisor;
          rem_d = '0;
          cnt_d = '0;
          if (divisor != '0) state_d = ST_CALC;
          else               pend_d  = 1'b1;
        end
      end
      ST_CALC: begin
        rem_d = step_rem;
        q_d   = step_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_IDLE;
          valid_d = 1'b1;
          quot_d  = step_q;
          remd_d  = step_rem[WIDTH-1:0];
          dbz_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      quot_q  <= '0;
      remd_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      quot_q  <= quot_d;
      remd_q  <= remd_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == ST_CALC);
  assign valid       = valid_q;
  assign quotient    = quot_q;
  assign remainder   = remd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider against an arithmetic
// reference (/ and %) with latency and handshake expectations.
module tb_seq_divider;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_r[$];
  logic             exp_z[$];
  int               exp_lat[$];

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .valid       (valid),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Called at a negedge: presents an operation for the next rising edge and
  // queues the result the arithmetic model says must come back.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    if (b == '0) begin
      exp_q.push_back({WIDTH{1'b1}});
      exp_r.push_back(a);
      exp_z.push_back(1'b1);
      exp_lat.push_back(1);
    end else begin
      exp_q.push_back(a / b);
      exp_r.push_back(a % b);
      exp_z.push_back(1'b0);
      exp_lat.push_back(WIDTH);
    end
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = WIDTH'($urandom);
    divisor  = WIDTH'($urandom);
  endtask

  // Waits (bounded) for valid; skip = edges already elapsed since acceptance.
  // Returns at the negedge where valid is high.
  task automatic await_result(input string tag, input int skip);
    logic [WIDTH-1:0] eq, er;
    logic             ez;
    int               el, n;
    logic             got;
    eq = exp_q.pop_front();
    er = exp_r.pop_front();
    ez = exp_z.pop_front();
    el = exp_lat.pop_front();
    n   = skip;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (valid) got = 1'b1;
      else chk({tag, "_busy"}, 32'(busy), 32'(!ez));
    end
    chk({tag, "_lat"}, 32'(n), 32'(el));
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    chk({tag, "_quot"}, 32'(quotient), 32'(eq));
    chk({tag, "_rem"}, 32'(remainder), 32'(er));
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
  endtask

  // One edge after a result with no new start: valid drops, outputs hold.
  task automatic check_hold(input string tag, input logic [WIDTH-1:0] q,
                            input logic [WIDTH-1:0] r, input logic z);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_valid_drop"}, 32'(valid), 32'd0);
    chk({tag, "_quot_hold"}, 32'(quotient), 32'(q));
    chk({tag, "_rem_hold"}, 32'(remainder), 32'(r));
    chk({tag, "_dbz_hold"}, 32'(div_by_zero), 32'(z));
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_quot", 32'(quotient), 32'd0);
    chk("rst_rem", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);

    // Basic and boundary operations
    issue(8'd100, 8'd7);   await_result("d100_7", 0);   check_hold("d100_7", 8'd14, 8'd2, 1'b0);
    issue(8'd255, 8'd1);   await_result("d255_1", 0);   check_hold("d255_1", 8'd255, 8'd0, 1'b0);
    issue(8'd3, 8'd200);   await_result("d3_200", 0);
    issue(8'd0, 8'd9);     await_result("d0_9", 0);     check_hold("d0_9", 8'd0, 8'd0, 1'b0);

    // Divide by zero
    issue(8'd5, 8'd0);     await_result("d5_0", 0);     check_hold("d5_0", 8'hFF, 8'd5, 1'b1);

    // Start while busy is ignored, then back-to-back start in the valid cycle
    issue(8'd200, 8'd13);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    @(posedge clk);
    #1;
    start = 1'b0; dividend = 8'd0; divisor = 8'd0;
    await_result("busy_ignore", 3);
    issue(8'd50, 8'd5);    await_result("b2b", 0);      check_hold("b2b", 8'd10, 8'd0, 1'b0);

    // Asynchronous reset mid-operation
    issue(8'd100, 8'd7);
    void'(exp_q.pop_front()); void'(exp_r.pop_front());
    void'(exp_z.pop_front()); void'(exp_lat.pop_front());
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_quot", 32'(quotient), 32'd0);
    chk("arst_rem", 32'(remainder), 32'd0);
    chk("arst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("arst_no_valid", 32'(valid), 32'd0);
    end
    issue(8'd9, 8'd4);     await_result("after_rst", 0); check_hold("after_rst", 8'd2, 8'd1, 1'b0);

    // Randomized back-to-back operations, including divide by zero
    for (int i = 0; i < 1000; i++) begin
      ra = WIDTH'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom_range(0, 255));
      issue(ra, rb);
      await_result("rand", 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
